uart_receiver: RTL and testbench
================================

# uart_receiver

Single-clock UART receive stage for the MIPS peripheral subsystem. It sits directly upstream of the memory-mapped peripheral block. It oversamples the serial line at 16× baud, deserialises 8N1 frames LSB-first, and hands each byte to the peripheral as a data word plus a one-cycle valid strobe. It replaces separate baud and sample clocks with an internal tick divider, so everything runs on the system clock.

## Interface
- DIV, 651: system-clock cycles per oversample tick. 651 gives 9600 baud × 16 at 100 MHz. Legal range 2..65535.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- UART_RX  input  1  asynchronous serial line, idle high.
- RX_DATA  output  8  last correctly received byte.
- RX_STATUS  output  1  one-cycle strobe: RX_DATA updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high whenever FSM is not IDLE.

## Operation
- Synchroniser: 2-flop chain on UART_RX; FSM uses only the second flop (rx_s).
- Tick divider: 16-bit counter runs 0..DIV-1 and wraps. tick=1 for one cycle when counter==DIV-1. Free-running; not restarted by frame events.
- Sample counter cnt (4 bit), bit index idx (3 bit), shift register sh (8 bit).
- FSM states: IDLE, START, DATA, STOP, BREAK. All transitions and counter updates below occur only on tick cycles.
  - IDLE: if rx_s==0, go to START with cnt←0.
  - START: if cnt==7, evaluate rx_s. rx_s==0 goes to DATA with cnt←0, idx←0. rx_s==1 is a glitch: go to IDLE, no output. Otherwise cnt←cnt+1.
  - DATA: if cnt==15, sh←{rx_s, sh[7:1]} and cnt←0. If idx==7, go to STOP; else idx←idx+1. Otherwise cnt←cnt+1.
  - STOP: if cnt==15, evaluate rx_s. rx_s==1: RX_DATA←sh, RX_STATUS=1, go to IDLE. rx_s==0: frame_err=1, RX_DATA unchanged, go to BREAK. Otherwise cnt←cnt+1.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line being read as repeated starts.
- Each bit is sampled near its centre: 8 ticks after start detection, then every 16 ticks.
- No flow control. A new byte overwrites RX_DATA; the consumer must latch RX_DATA on RX_STATUS.

## Timing
- Reset values: RX_DATA=0x00, RX_STATUS=0, frame_err=0, busy=0. Synchroniser flops are 1; divider, cnt, idx and sh are 0; state is IDLE.
- Reset mid-frame: the partial frame is discarded, with no strobe. busy=0 from the cycle after reset is sampled.
- Input latency: 2 cycles for the synchroniser, plus up to DIV cycles until the next tick.
- RX_STATUS and RX_DATA change in the cycle after the tick that samples the stop bit. That is about 9.5 bit times after the falling start edge. RX_STATUS is high for exactly one cycle.
- frame_err is exactly one cycle wide. It never coincides with RX_STATUS.
- busy rises in the cycle after start detection. It falls in the same cycle the strobe asserts.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The FSM is back in IDLE about half a bit before the next start edge.
- Baud tolerance: correct reception with up to ±3% transmitter rate mismatch.

## Test plan
- DIV=4 (bit = 64 clk): send 0x55 → exactly one RX_STATUS pulse, RX_DATA=0x55, frame_err never high, busy low afterward.
- DIV=4: send 0xA3 then 0x0F with no idle gap → two RX_STATUS pulses about 640 clk apart, RX_DATA=0xA3 then 0x0F.
- DIV=4: drive UART_RX low for 12 clk, then high → busy pulses, no RX_STATUS, no frame_err, FSM back in IDLE.
- DIV=4: after receiving 0x3C, send 0x81 with the stop bit low and the line held low for 3 bit times → one frame_err pulse, no RX_STATUS, RX_DATA stays 0x3C, busy stays high until the line rises. A following 0xC3 frame is then received correctly.
- DIV=4: assert reset for 1 cycle during data bit 4 of 0xFF → all outputs at reset values the next cycle. The rest of the frame produces no strobe; the next frame 0x12 yields RX_DATA=0x12.
- DIV=651, 100 MHz clock: send 0x00, 0xFF and 0x5A at 9600 baud scaled by 0.97 and by 1.03 → all bytes received correctly, no frame_err.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte plus strobes out, between the UART receiver
// and the memory-mapped peripheral block.
`timescale 1ns/1ps
interface uart_receiver_if;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       frame_err;
    logic       busy;

    modport master (
        input  UART_RX,
        output RX_DATA,
        output RX_STATUS,
        output frame_err,
        output busy
    );

    modport slave (
        output UART_RX,
        input  RX_DATA,
        input  RX_STATUS,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampling from a free-running tick divider on the
// system clock; emits each byte with a one-cycle RX_STATUS strobe.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int DIV = 651
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t     state, state_n;
    logic       rx_p0, rx_s;
    logic [15:0] div_cnt;
    logic       tick;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic [7:0] data, data_n;
    logic       status, status_n;
    logic       ferr, ferr_n;

    // stage p0 -> s: two-flop synchroniser, idle-high reset value
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= bus.UART_RX;
            rx_s  <= rx_p0;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            data   <= '0;
            status <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            data   <= data_n;
            status <= status_n;
            ferr   <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sh_n     = sh;
        data_n   = data;
        status_n = 1'b0;
        ferr_n   = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // Half a bit in: a line that has gone high again was a glitch.
                    if (cnt == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            cnt_n   = '0;
                            idx_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt == 4'd15) begin
                        sh_n  = {rx_s, sh[7:1]};
                        cnt_n = '0;
                        if (idx == 3'd7) state_n = STOP;
                        else             idx_n   = idx + 3'd1;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (cnt == 4'd15) begin
                        if (rx_s) begin
                            data_n   = sh;
                            status_n = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                BREAK: begin
                    // A held-low line must rise before another start is accepted.
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.RX_DATA   = data;
    assign bus.RX_STATUS = status;
    assign bus.frame_err = ferr;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a fast instance (DIV=4) for functional cases and a
// DIV=13 instance driven with +/-3% skewed bit rates.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam real BIT4  = 640.0;   // 16*4 clk of 10 ns
    localparam real BIT13 = 2080.0;  // 16*13 clk of 10 ns

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst13;
    uart_receiver_if bus4();
    uart_receiver_if bus13();

    uart_receiver #(.DIV(4))  u_div4  (.clk(clk), .reset(rst4),  .bus(bus4));
    uart_receiver #(.DIV(13)) u_div13 (.clk(clk), .reset(rst13), .bus(bus13));

    int total = 0;
    int bad   = 0;

    logic [7:0] q4[$];
    logic [7:0] q13[$];
    time        t4[$];
    int rd4 = 0;
    int rd13 = 0;
    int fe4 = 0;
    int fe13 = 0;
    int busy_cnt4 = 0;
    int clash = 0;
    int wide = 0;
    int busy_at_strobe = 0;
    logic st4_d = 1'b0, fe4_d = 1'b0, st13_d = 1'b0, fe13_d = 1'b0;
    time last_start = 0;

    always @(negedge clk) begin
        if (bus4.RX_STATUS) begin
            q4.push_back(bus4.RX_DATA);
            t4.push_back($time);
        end
        if (bus13.RX_STATUS) q13.push_back(bus13.RX_DATA);
        if (bus4.frame_err)  fe4  <= fe4 + 1;
        if (bus13.frame_err) fe13 <= fe13 + 1;
        if (bus4.busy)       busy_cnt4 <= busy_cnt4 + 1;
        if ((bus4.RX_STATUS && bus4.frame_err) || (bus13.RX_STATUS && bus13.frame_err))
            clash <= clash + 1;
        if ((bus4.RX_STATUS && st4_d) || (bus4.frame_err && fe4_d) ||
            (bus13.RX_STATUS && st13_d) || (bus13.frame_err && fe13_d))
            wide <= wide + 1;
        if ((bus4.RX_STATUS && bus4.busy) || (bus13.RX_STATUS && bus13.busy))
            busy_at_strobe <= busy_at_strobe + 1;
        st4_d  <= bus4.RX_STATUS;
        fe4_d  <= bus4.frame_err;
        st13_d <= bus13.RX_STATUS;
        fe13_d <= bus13.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) bus4.UART_RX = v;
        else          bus13.UART_RX = v;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; line is left at the stop level.
    task automatic send_frame(input int sel, input logic [7:0] b, input real bit_ns, input logic stop);
        last_start = $time;
        drive(sel, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            #(bit_ns);
        end
        drive(sel, stop);
        #(bit_ns);
    endtask

    task automatic expect_byte(input int sel, input string tag, input logic [7:0] exp);
        if (sel == 0) begin
            if (rd4 < q4.size()) begin
                check(tag, {24'd0, q4[rd4]}, {24'd0, exp});
                rd4++;
            end else begin
                check({tag, "_missing"}, 32'hFFFF_FFFF, {24'd0, exp});
            end
        end else begin
            if (rd13 < q13.size()) begin
                check(tag, {24'd0, q13[rd13]}, {24'd0, exp});
                rd13++;
            end else begin
                check({tag, "_missing"}, 32'hFFFF_FFFF, {24'd0, exp});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},   {24'd0, bus4.RX_DATA}, 32'd0);
        check({tag, "_status"}, {31'd0, bus4.RX_STATUS}, 32'd0);
        check({tag, "_ferr"},   {31'd0, bus4.frame_err}, 32'd0);
        check({tag, "_busy"},   {31'd0, bus4.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] rnd_bytes[$];
        logic [7:0] tol_bytes[$];
        real        scales[2];
        longint     d, lo, hi;
        int         fe_before, busy_before, n_before;

        bus4.UART_RX  = 1'b1;
        bus13.UART_RX = 1'b1;
        rst4  = 1'b1;
        rst13 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_busy13", {31'd0, bus13.busy}, 32'd0);
        rst4  = 1'b0;
        rst13 = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, plus arrival time ~9.5 bit times after the start edge.
        send_frame(0, 8'h55, BIT4, 1'b1);
        #(3 * BIT4);
        expect_byte(0, "t1_data", 8'h55);
        check("t1_count", q4.size(), 32'd1);
        check("t1_ferr", fe4, 32'd0);
        check("t1_busy", {31'd0, bus4.busy}, 32'd0);
        lo = 608;
        hi = 608 + 4 + 4;
        d  = (t4.size() > 0) ? longint'((t4[0] - last_start) / 10) : 0;
        check("t1_latency_in_range", {31'd0, (d >= lo && d <= hi)}, 32'd1);

        // Back-to-back frames, no idle gap.
        @(negedge clk);
        send_frame(0, 8'hA3, BIT4, 1'b1);
        send_frame(0, 8'h0F, BIT4, 1'b1);
        #(3 * BIT4);
        expect_byte(0, "t2_first", 8'hA3);
        expect_byte(0, "t2_second", 8'h0F);
        d = (t4.size() > 2) ? longint'((t4[2] - t4[1]) / 10) : 0;
        check("t2_spacing", {31'd0, (d >= 636 && d <= 644)}, 32'd1);

        // Short low glitch: busy for about half a bit, no output at all.
        busy_before = busy_cnt4;
        n_before    = q4.size();
        fe_before   = fe4;
        @(negedge clk);
        drive(0, 1'b0);
        repeat (12) @(negedge clk);
        drive(0, 1'b1);
        #(2 * BIT4);
        d = longint'(busy_cnt4 - busy_before);
        check("t3_busy_pulse", {31'd0, (d >= 28 && d <= 40)}, 32'd1);
        check("t3_no_strobe", q4.size(), n_before);
        check("t3_no_ferr", fe4, fe_before);
        check("t3_idle", {31'd0, bus4.busy}, 32'd0);

        // Framing error followed by a held-low line, then recovery.
        send_frame(0, 8'h3C, BIT4, 1'b1);
        #(BIT4);
        expect_byte(0, "t4_pre", 8'h3C);
        fe_before = fe4;
        n_before  = q4.size();
        send_frame(0, 8'h81, BIT4, 1'b0);
        #(3 * BIT4);
        check("t4_busy_held", {31'd0, bus4.busy}, 32'd1);
        drive(0, 1'b1);
        #(2 * BIT4);
        check("t4_ferr_once", fe4, fe_before + 1);
        check("t4_no_strobe", q4.size(), n_before);
        check("t4_data_kept", {24'd0, bus4.RX_DATA}, 32'h3C);
        check("t4_busy_released", {31'd0, bus4.busy}, 32'd0);
        send_frame(0, 8'hC3, BIT4, 1'b1);
        #(2 * BIT4);
        expect_byte(0, "t4_after", 8'hC3);

        // Reset pulse in the middle of data bit 4 of 0xFF.
        @(negedge clk);
        n_before = q4.size();
        fork
            send_frame(0, 8'hFF, BIT4, 1'b1);
            begin
                #(5.5 * BIT4);
                @(negedge clk);
                rst4 = 1'b1;
                @(negedge clk);
                rst4 = 1'b0;
                check_reset_outputs("t5_reset");
            end
        join
        #(2 * BIT4);
        check("t5_no_strobe", q4.size(), n_before);
        send_frame(0, 8'h12, BIT4, 1'b1);
        #(2 * BIT4);
        expect_byte(0, "t5_next", 8'h12);

        // Random bytes with random idle gaps (0 = back-to-back).
        fe_before = fe4;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            int gap;
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 2));
            rnd_bytes.push_back(b);
            send_frame(0, b, BIT4, 1'b1);
            #(gap * BIT4);
        end
        #(3 * BIT4);
        foreach (rnd_bytes[i]) expect_byte(0, "rnd_data", rnd_bytes[i]);
        check("rnd_count", q4.size(), rd4);
        check("rnd_ferr", fe4, fe_before);

        // Transmitter running 3% fast and 3% slow.
        scales[0] = 0.97;
        scales[1] = 1.03;
        for (int s = 0; s < 2; s++) begin
            logic [7:0] list[$];
            list = '{8'h00, 8'hFF, 8'h5A, 8'($urandom), 8'($urandom)};
            foreach (list[i]) begin
                int gap;
                gap = int'($urandom_range(0, 1));
                tol_bytes.push_back(list[i]);
                send_frame(1, list[i], BIT13 * scales[s], 1'b1);
                #(gap * BIT13 * scales[s]);
            end
        end
        #(3 * BIT13);
        foreach (tol_bytes[i]) expect_byte(1, "tol_data", tol_bytes[i]);
        check("tol_count", q13.size(), rd13);
        check("tol_ferr", fe13, 32'd0);

        check("strobe_ferr_disjoint", clash, 32'd0);
        check("strobe_one_cycle", wide, 32'd0);
        check("busy_low_at_strobe", busy_at_strobe, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
